// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round/sigma helpers for the
// multi-block hasher and its message-schedule window.
package sha256_pkg;

   typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE, DONE} state_e;

   // Eight 32-bit words; index 0 is a (or h0), index 7 is h (or h7).
   typedef logic [7:0][31:0] hash_t;

   // h7 is listed first so that h0 lands in index 0.
   localparam hash_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                           32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
   endfunction

   function automatic hash_t sha256_round(input hash_t s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] s1, ch, t1, s0, maj, t2;
      hash_t       r;
      s1   = rightrotate(s[4], 6) ^ rightrotate(s[4], 11) ^ rightrotate(s[4], 25);
      ch   = (s[4] & s[5]) ^ (~s[4] & s[6]);
      t1   = s[7] + s1 + ch + k + w;
      s0   = rightrotate(s[0], 2) ^ rightrotate(s[0], 13) ^ rightrotate(s[0], 22);
      maj  = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
      t2   = s0 + maj;
      r[7] = s[6];
      r[6] = s[5];
      r[5] = s[4];
      r[4] = s[3] + t1;
      r[3] = s[2];
      r[2] = s[1];
      r[1] = s[0];
      r[0] = t1 + t2;
      return r;
   endfunction

endpackage

// File: rtl/sha256_w_sched.sv
// Rolling 16-word message schedule: words enter at the top, the round
// consumes the bottom word, and W[t+16] is generated on the fly.
module sha256_w_sched
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic        shift,
   output logic [31:0] next_word
);

   logic [15:0][31:0] win;
   logic [31:0]       expanded;

   // win[0] holds W[t]; W[t+16] depends on W[t+14], W[t+9], W[t+1] and W[t].
   assign next_word = win[0];
   assign expanded  = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

   always_ff @(posedge clk) begin
      if (load)
         win <= {load_word, win[15:1]};
      else if (shift)
         win <= {expanded, win[15:1]};
   end

endmodule

// File: rtl/sha256_multi_block.sv
// SHA-256 of a fixed-length word message held in memory, with padding generated
// internally; the digest is written back as eight words.
module sha256_multi_block
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 20,
   parameter int ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [ADDR_W-1:0] output_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_clk,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   localparam int NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
   localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);
   localparam int P_W        = 17;
   localparam logic [P_W-1:0]   MSG_END  = P_W'(NUM_OF_WORDS);
   localparam logic [P_W-1:0]   LEN_IDX  = P_W'(16 * NUM_BLOCKS - 1);
   localparam logic [31:0]      LEN_BITS = 32'(NUM_OF_WORDS * 32);
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

   state_e            state, state_d;
   logic [6:0]        cnt;
   logic [BLK_W-1:0]  blk;
   logic [ADDR_W-1:0] msg_base, out_base;
   hash_t             hash, work;
   logic [P_W-1:0]    p_rd, p_ld;
   logic [31:0]       pad_word, w_t;
   logic              sched_load, sched_shift;

   assign mem_clk = clk;

   // READ cycle n presents padded word n; its data is consumed one cycle later.
   assign p_rd = (P_W'(blk) << 4) + P_W'(cnt);
   assign p_ld = p_rd - P_W'(1);

   always_comb begin
      if (p_ld < MSG_END)       pad_word = mem_read_data;
      else if (p_ld == MSG_END) pad_word = 32'h8000_0000;
      else if (p_ld == LEN_IDX) pad_word = LEN_BITS;
      else                      pad_word = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         blk   <= '0;
      end else begin
         state <= state_d;
         cnt   <= (state_d != state) ? 7'd0 : cnt + 7'd1;
         if (state == IDLE)        blk <= '0;
         else if (state == UPDATE) blk <= blk + BLK_W'(1);
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d        = state;
      busy           = (state != IDLE);
      done           = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      sched_load     = 1'b0;
      sched_shift    = 1'b0;
      case (state)
         IDLE:    if (start) state_d = READ;
         READ: begin
            if (cnt < 7'd16 && p_rd < MSG_END) mem_addr = msg_base + ADDR_W'(p_rd);
            sched_load = (cnt != 7'd0);
            if (cnt == 7'd16) state_d = COMPUTE;
         end
         COMPUTE: begin
            sched_shift = 1'b1;
            if (cnt == 7'd63) state_d = UPDATE;
         end
         UPDATE:  state_d = (blk == LAST_BLK) ? WRITE : READ;
         WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = out_base + ADDR_W'(cnt);
            mem_write_data = hash[cnt[2:0]];
            if (cnt == 7'd7) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: datapath registers carry no reset; each is loaded before it is read,
   // and leaving them out keeps the reset net off the wide hash/round logic.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         msg_base <= message_addr;
         out_base <= output_addr;
         hash     <= IV;
      end
      if (state == READ && cnt == 7'd0) work <= hash;
      if (state == COMPUTE) work <= sha256_round(work, K[cnt[5:0]], w_t);
      if (state == UPDATE) begin
         for (int i = 0; i < 8; i++) hash[i] <= hash[i] + work[i];
      end
   end

   sha256_w_sched u_w_sched (
      .clk       (clk),
      .load      (sched_load),
      .load_word (pad_word),
      .shift     (sched_shift),
      .next_word (w_t)
   );

endmodule

// File: tb/tb_sha256_multi_block.sv
// Randomised bench for sha256_multi_block: four instances of different lengths
// share one memory model and are checked against a plain SHA-256 reference.
module tb_sha256_multi_block;

   localparam int NW [4] = '{1, 13, 14, 20};

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_v        [4];
   logic [15:0] msg_v          [4];
   logic [15:0] out_v          [4];
   logic        busy_v         [4];
   logic        done_v         [4];
   logic        mem_clk_v      [4];
   logic        mem_we_v       [4];
   logic [15:0] mem_addr_v     [4];
   logic [31:0] mem_write_data_v [4];
   logic [31:0] rd_v           [4];

   logic [31:0] mem  [65536];
   logic [31:0] wmem [65536];
   int          act_g = 0;
   logic [15:0] exp_out = '0;
   logic        mon_clear = 1'b1;
   int          wr_cnt = 0, wr_bad = 0, done_cnt = 0;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha256_multi_block #(.NUM_OF_WORDS(NW[g]), .ADDR_W(16)) dut (
         .clk            (clk),
         .reset_n        (reset_n),
         .start          (start_v[g]),
         .message_addr   (msg_v[g]),
         .output_addr    (out_v[g]),
         .busy           (busy_v[g]),
         .done           (done_v[g]),
         .mem_clk        (mem_clk_v[g]),
         .mem_we         (mem_we_v[g]),
         .mem_addr       (mem_addr_v[g]),
         .mem_write_data (mem_write_data_v[g]),
         .mem_read_data  (rd_v[g])
      );
   end

   // Memory model (one-cycle read latency) and write/done monitor.
   always @(posedge clk) begin
      for (int g = 0; g < 4; g++) rd_v[g] <= mem[mem_addr_v[g]];
      if (mon_clear) begin
         wr_cnt   <= 0;
         wr_bad   <= 0;
         done_cnt <= 0;
      end else begin
         for (int g = 0; g < 4; g++) begin
            if (mem_we_v[g]) begin
               if (g != act_g || mem_addr_v[g] != exp_out + 16'(wr_cnt)) wr_bad <= wr_bad + 1;
               wmem[mem_addr_v[g]] <= mem_write_data_v[g];
               wr_cnt <= wr_cnt + 1;
            end
         end
         if (done_v[act_g]) done_cnt <= done_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight FIPS 180-4: pad into a word queue, expand 64 words, compress.
   function automatic logic [255:0] ref_digest(input int n, input logic [15:0] base);
      logic [31:0] q [$];
      logic [31:0] w [64];
      logic [31:0] h [8];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      for (int i = 0; i < n; i++) q.push_back(mem[base + 16'(i)]);
      q.push_back(32'h8000_0000);
      while (q.size() % 16 != 14) q.push_back(32'h0);
      q.push_back(32'h0);
      q.push_back(32'(n * 32));
      h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      for (int b = 0; b < q.size() / 16; b++) begin
         for (int t = 0; t < 16; t++) w[t] = q[b * 16 + t];
         for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
         v = h;
         for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
      end
      return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
   endfunction

   task automatic fill(input logic [15:0] msg, input int n);
      for (int i = 0; i < n; i++) mem[msg + 16'(i)] = $urandom;
   endtask

   // Ends at the negedge following the start-sample edge.
   task automatic launch(input int g, input logic [15:0] msg, input logic [15:0] out, input bit hold);
      @(negedge clk);
      act_g = g; exp_out = out; mon_clear = 1'b1;
      msg_v[g] = msg; out_v[g] = out; start_v[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mon_clear = 1'b0;
      if (!hold) begin
         start_v[g] = 1'b0;
         msg_v[g]   = 16'($urandom);
         out_v[g]   = 16'($urandom);
      end
   endtask

   // lat = number of edges from the start-sample edge to the edge that captures done.
   task automatic wait_done(input int g, input bit poke, output int lat);
      int cyc = 0;
      lat = -1;
      while (cyc < 2000) begin
         if (done_v[g]) begin
            lat = cyc + 1;
            break;
         end
         if (poke) start_v[g] = (cyc == 40);
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      if (lat < 0) check("done timeout", done_v[g], 1'b1);
   endtask

   task automatic verify(input string tag, input int n, input logic [15:0] msg, input int lat,
                         output logic [255:0] got);
      int nb = (n + 3 + 15) / 16;
      check({tag, " latency"}, lat, 82 * nb + 9);
      @(negedge clk);
      check({tag, " done one cycle"}, done_v[act_g], 1'b0);
      repeat (3) @(negedge clk);
      check({tag, " write count"}, wr_cnt, 8);
      check({tag, " stray writes"}, wr_bad, 0);
      check({tag, " done pulses"}, done_cnt, 1);
      got = '0;
      for (int i = 0; i < 8; i++) got = {got[223:0], wmem[exp_out + 16'(i)]};
      check({tag, " digest"}, got, ref_digest(n, msg));
   endtask

   task automatic run_one(input string tag, input int g, input logic [15:0] msg,
                          input logic [15:0] out, input bit poke, output logic [255:0] got);
      int lat;
      launch(g, msg, out, 1'b0);
      wait_done(g, poke, lat);
      verify(tag, NW[g], msg, lat, got);
   endtask

   initial begin
      logic [255:0] dg, dg2;
      logic [15:0]  msg, out;
      int           lat, g;
      for (int i = 0; i < 4; i++) begin
         start_v[i] = 1'b0; msg_v[i] = '0; out_v[i] = '0;
      end
      #3;
      for (int i = 0; i < 4; i++)
         check($sformatf("reset outputs %0d", i),
               {busy_v[i], done_v[i], mem_we_v[i], mem_addr_v[i], mem_write_data_v[i]}, '0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("mem_clk low phase", mem_clk_v[0], clk);
      @(posedge clk); #1;
      check("mem_clk high phase", mem_clk_v[0], clk);

      // Known answer: "abcd"
      msg = 16'($urandom); out = 16'($urandom);
      mem[msg] = 32'h61626364;
      run_one("abcd", 0, msg, out, 1'b0, dg);
      check("abcd known digest", dg,
            256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);

      msg = 16'($urandom); fill(msg, 13);
      run_one("n13", 1, msg, 16'($urandom), 1'b0, dg);
      msg = 16'($urandom); fill(msg, 14);
      run_one("n14", 2, msg, 16'($urandom), 1'b0, dg);

      // Message spanning the top of the address space.
      fill(16'hFFF8, 20);
      run_one("n20 wrap", 3, 16'hFFF8, 16'h4000, 1'b0, dg);

      // Start pulsed during COMPUTE must not restart or change the result.
      run_one("n20 poke", 3, 16'hFFF8, 16'h5000, 1'b1, dg2);
      check("poke digest unchanged", dg2, dg);

      // Start held high through DONE begins a second hash right after IDLE.
      msg = 16'($urandom); out = 16'($urandom); fill(msg, 1);
      launch(0, msg, out, 1'b1);
      wait_done(0, 1'b0, lat);
      check("held first latency", lat, 91);
      @(negedge clk);
      check("held idle gap", busy_v[0], 1'b0);
      mon_clear = 1'b1;
      @(negedge clk);
      mon_clear = 1'b0;
      check("held restart", busy_v[0], 1'b1);
      start_v[0] = 1'b0;
      wait_done(0, 1'b0, lat);
      verify("held second", 1, msg, lat, dg);

      // Reset in the middle of a hash, then a fresh run.
      msg = 16'($urandom); out = 16'($urandom); fill(msg, 20);
      launch(3, msg, out, 1'b0);
      repeat (50) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset outputs",
            {busy_v[3], done_v[3], mem_we_v[3], mem_addr_v[3], mem_write_data_v[3]}, '0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      check("midreset no writes", wr_cnt, 0);
      check("midreset no done", done_cnt, 0);
      check("midreset idle", busy_v[3], 1'b0);
      run_one("after reset", 3, msg, out, 1'b0, dg);

      for (int r = 0; r < 4; r++) begin
         g = int'($urandom_range(0, 3));
         msg = 16'($urandom);
         fill(msg, NW[g]);
         run_one($sformatf("random %0d", r), g, msg, 16'($urandom), 1'b0, dg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_multi_block.md
SHA256_MULTI_BLOCK -- requirements
Module: sha256_multi_block

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, message length in 32-bit words; legal range 1..4095.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have input clk, 1 bit, sole clock.
REQ-004 SHALL have input reset_n, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have input start, 1 bit, request a hash; sampled only in IDLE.
REQ-006 SHALL have inputs message_addr and output_addr, ADDR_W bits each: first message word address and first digest word address.
REQ-007 SHALL have output busy, 1 bit, high in every state except IDLE.
REQ-008 SHALL have output done, 1 bit, one-cycle completion pulse.
REQ-009 SHALL have outputs mem_clk (1, equals clk), mem_we (1), mem_addr (ADDR_W) and mem_write_data (32).
REQ-010 SHALL have input mem_read_data, 32 bits, valid one cycle after its address is presented.

Function
REQ-011 SHALL compute FIPS 180-4 SHA-256 of NUM_OF_WORDS big-endian words with generated padding, for any legal length.
REQ-012 SHALL use block count B = (NUM_OF_WORDS+2)/16 + 1, integer division.
REQ-013 SHALL source padded word index p as follows:
- p < N: memory;
- p == N: 0x80000000;
- p == 16B-1: N*32;
- any other p: zero.
REQ-014 SHALL NOT issue a memory access for padding words; mem_we is 0 throughout READ.
REQ-015 SHALL latch message_addr and output_addr when start is accepted; later input changes are ignored.
REQ-016 SHALL use states IDLE, READ, COMPUTE, UPDATE, WRITE and DONE, with these transitions:
- IDLE->READ on start;
- READ (17 cycles)->COMPUTE;
- COMPUTE (64 cycles, one round per cycle)->UPDATE;
- UPDATE (1 cycle)->READ if blocks remain, else ->WRITE;
- WRITE (8 cycles)->DONE;
- DONE (1 cycle, done=1)->IDLE.
REQ-017 SHALL load a..h from IV before block 0 and from h0..h7 before each later block; UPDATE adds a..h into h0..h7 modulo 2^32.
REQ-018 SHALL expand the message schedule on the fly in a 16-entry rolling window, with no 64-entry array.
REQ-019 SHALL write h0..h7 during WRITE to output_addr+0..+7 (mem_we=1), one word per cycle, in order.
REQ-020 SHALL use total latency from the start-sample edge to the done pulse of exactly 82*B+9 cycles; N=20 gives 173.
REQ-021 SHALL ignore start while busy; start held high through DONE begins a new hash from the IDLE cycle that follows.
REQ-022 SHALL wrap all address arithmetic modulo 2^ADDR_W.

Reset
REQ-023 SHALL, on reset_n low, immediately force state=IDLE and busy=0, done=0, mem_we=0, mem_addr=0 and mem_write_data=0.
REQ-024 SHALL abandon any hash when reset occurs mid-operation; no further memory writes follow, and the first start after release begins a fresh hash.
REQ-025 SHALL leave datapath registers (w window, a..h, h0..h7) without reset; they are loaded before use.

Structure
REQ-026 SHALL place the K[0:63] table, IV constants, state enum, rightrotate function and round function in shared package sha256_pkg.
REQ-027 SHALL implement the rolling schedule as sub-module sha256_w_sched, with load, shift and next-word output.
REQ-028 SHALL fit in 120-400 lines of RTL and be synthesisable.

Verification
REQ-029 SHALL cover N=1 with word 0x61626364 ("abcd"): digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589 at output_addr; done at cycle 91.
REQ-030 SHALL cover N=13 (B=1) and N=14 (B=2, length alone in block 2): digests match the software model; done at cycles 91 and 173.
REQ-031 SHALL cover N=20 with message_addr=0xFFF8: reads wrap to 0x0000..0x000B; digest matches the model; no writes occur outside output_addr..+7.
REQ-032 SHALL cover start pulsed during COMPUTE: no restart occurs, exactly one done pulse, and an unchanged digest.
REQ-033 SHALL cover reset_n low at cycle 50, then start: mem_we=0 immediately, and the second run gives the correct digest with the standard latency.
